// File: rtl/keypad_4x4_cntr_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (package only).
// Backpressure: n/a; key events are pulses with no ready handshake.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] COL0     = 4'b1110;
  localparam logic [3:0] COL1     = 4'b1101;
  localparam logic [3:0] COL2     = 4'b1011;
  localparam logic [3:0] COL3     = 4'b0111;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // True when exactly one line of an active-low nibble is pulled low.
  function automatic logic single_low(input logic [3:0] v);
    return (v == COL0) || (v == COL1) || (v == COL2) || (v == COL3);
  endfunction

  // Position of the low bit in a one-hot-low nibble (0 for anything else).
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      COL1:    idx = 2'd1;
      COL2:    idx = 2'd2;
      COL3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_4x4_cntr_if.sv
// Keypad-side bus: row sense in, column drive and key events out.
// Latency: n/a (signal bundle). Optional entry field under KEYPAD_ENTRY_EN.
// Backpressure: none; key_valid is a single-cycle pulse.
interface keypad_4x4_cntr_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_value;
  logic        key_valid;
  logic        key_pressed;
`ifdef KEYPAD_ENTRY_EN
  logic [15:0] entry;

  modport master (input row, output col, output key_value, output key_valid,
                  output key_pressed, output entry);
  modport slave  (output row, input col, input key_value, input key_valid,
                  input key_pressed, input entry);
`else
  modport master (input row, output col, output key_value, output key_valid,
                  output key_pressed);
  modport slave  (output row, input col, input key_value, input key_valid,
                  input key_pressed);
`endif
endinterface

// File: rtl/keypad_4x4_cntr_ring.sv
// One-hot-low column rotator: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
// Latency: advances one position on the clock after enable is high.
// Backpressure: holds its code whenever enable is low.
module ring_counter_keypad
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [3:0] col
);

  // Rotate left so the low bit walks toward the MSB and wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    col <= COL0;
    else if (enable) col <= {col[2:0], col[3]};
  end

endmodule

// File: rtl/keypad_4x4_cntr.sv
// 4x4 keypad scanner with press/release debounce; optional 4-key entry
// register under KEYPAD_ENTRY_EN. Latency: 2-clock row sync, then
// SCAN_DIV per column and DEBOUNCE_CNT to confirm. Backpressure: none.
module keypad_4x4_cntr
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 10000,
  parameter int DEBOUNCE_CNT = 100000
) (
  input  logic               clk,
  input  logic               reset_n,
  keypad_4x4_cntr_if.master  bus
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);

  logic [3:0]    row_meta;
  logic [3:0]    row_s;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          rotate;
  logic          latch;
  logic          confirm;
  logic          release_done;
  logic [3:0]    col;
  logic [3:0]    lat_row;
  logic [1:0]    lat_col;
  logic [3:0]    key_value_q;
  logic          key_valid_q;
  logic          key_pressed_q;

  // Bring the asynchronous row lines into the clock domain; idle is all-high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= ROW_IDLE;
      row_s    <= ROW_IDLE;
    end else begin
      row_meta <= bus.row;
      row_s    <= row_meta;
    end
  end

  ring_counter_keypad u_ring (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (rotate),
    .col     (col)
  );

  // State and shared period/debounce counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SCAN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: the counter restarts on every transition and on column wrap.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CW'(1);
    rotate       = 1'b0;
    latch        = 1'b0;
    confirm      = 1'b0;
    release_done = 1'b0;
    unique case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (single_low(row_s)) begin
            latch     = 1'b1;
            state_nxt = DEBOUNCE;
          end else begin
            rotate = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (row_s != lat_row) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
          rotate    = 1'b1;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          confirm   = 1'b1;
        end
      end
      HOLD: begin
        // Row changes while held, including a second key, are ignored.
        cnt_nxt = '0;
        if (row_s == ROW_IDLE) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (row_s != ROW_IDLE) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt    = SCAN;
          cnt_nxt      = '0;
          release_done = 1'b1;
          rotate       = 1'b1;
        end
      end
      default: begin
        state_nxt = SCAN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Capture the candidate key at the end of a column period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_row <= ROW_IDLE;
      lat_col <= 2'd0;
    end else if (latch) begin
      lat_row <= row_s;
      lat_col <= low_index(col);
    end
  end

  // Key event outputs, updated together on confirmation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_value_q   <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      key_valid_q <= confirm;
      if (confirm) begin
        key_value_q   <= {low_index(lat_row), lat_col};
        key_pressed_q <= 1'b1;
      end else if (release_done) begin
        key_pressed_q <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_ENTRY_EN
  logic [15:0] entry_q;

  // Shift in each confirmed key; the oldest digit falls off the top.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     entry_q <= 16'h0000;
    else if (confirm) entry_q <= {entry_q[11:0], low_index(lat_row), lat_col};
  end

  assign bus.entry = entry_q;
`endif

  assign bus.col         = col;
  assign bus.key_value   = key_value_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_4x4_cntr.sv
// Bench for keypad_4x4_cntr: a behavioural keypad matrix drives the rows,
// a scoreboard queue holds expected keys, a monitor checks each key_valid.
// Entry checks compile in when KEYPAD_ENTRY_EN is defined.
module tb_keypad_4x4_cntr;

  localparam int SD = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  keypad_4x4_cntr_if kif ();

  keypad_4x4_cntr #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (kif)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  // Physical keypad: key k sits on row k/4, column k%4; a pressed key
  // pulls its row low while its column is driven low.
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  row_drv;
  always_comb begin
    row_drv = 4'hF;
    for (int k = 0; k < 16; k++)
      if (pressed[k] && (kif.col[k % 4] == 1'b0)) row_drv[k / 4] = 1'b0;
  end
  assign kif.row = row_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] next_col(input logic [3:0] c);
    logic [3:0] seq [4];
    logic [3:0] n;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    n = 4'bxxxx;
    for (int i = 0; i < 4; i++) if (seq[i] == c) n = seq[(i + 1) % 4];
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every key_valid pops one expected key.
  logic prev_valid = 1'b0;
`ifdef KEYPAD_ENTRY_EN
  logic [15:0] exp_entry = 16'h0000;
`endif
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
`ifdef KEYPAD_ENTRY_EN
      exp_entry = 16'h0000;
`endif
    end else begin
      if (kif.key_valid) begin
        check("valid_back_to_back", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_key_valid", {31'd0, kif.key_valid}, 32'd0);
        end else begin
          int k;
          k = exp_q.pop_front();
          check("key_value", {28'd0, kif.key_value}, k);
          check("key_pressed_at_valid", {31'd0, kif.key_pressed}, 32'd1);
`ifdef KEYPAD_ENTRY_EN
          exp_entry = {exp_entry[11:0], 4'(k)};
          check("entry_shift", {16'd0, kif.entry}, {16'd0, exp_entry});
`endif
        end
      end
      prev_valid = kif.key_valid;
    end
  end

  // Press one key, hold it, release it and time the key_pressed fall.
  task automatic press_key(input int k, input int hold, input int gap);
    int n;
    pressed[k] = 1'b1;
    exp_q.push_back(k);
    tick(hold);
    check("pressed_during_hold", {31'd0, kif.key_pressed}, 32'd1);
    pressed[k] = 1'b0;
    n = 0;
    while (kif.key_pressed && n < 60) begin
      tick(1);
      n++;
    end
    tests++;
    if (n < DB + 2 || n > DB + 3) begin
      fails++;
      $display("FAIL release_time: key_pressed fell %0d clocks after release, expected %0d..%0d",
               n, DB + 2, DB + 3);
    end
    tick(gap);
  endtask

  initial begin
    logic [3:0] prev;
    int run;
    int changes;
    bit first;

    // Reset state.
    reset_n = 1'b0;
    tick(3);
    check("rst_col", {28'd0, kif.col}, 32'hE);
    check("rst_key_value", {28'd0, kif.key_value}, 32'd0);
    check("rst_key_valid", {31'd0, kif.key_valid}, 32'd0);
    check("rst_key_pressed", {31'd0, kif.key_pressed}, 32'd0);
`ifdef KEYPAD_ENTRY_EN
    check("rst_entry", {16'd0, kif.entry}, 32'd0);
`endif
    reset_n = 1'b1;

    // Idle scan: column order and period.
    prev = kif.col;
    run = 0;
    first = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      run++;
      if (kif.col !== prev) begin
        check("col_order", {28'd0, kif.col}, {28'd0, next_col(prev)});
        if (!first) check("col_period", run, SD);
        first = 1'b0;
        run = 0;
        prev = kif.col;
      end
    end
    check("idle_key_value", {28'd0, kif.key_value}, 32'd0);
    check("idle_key_pressed", {31'd0, kif.key_pressed}, 32'd0);

    // Long press of key 9 (row 2, column 1).
    press_key(9, 200, 10);

    // Bounce on key 0, then a stable press.
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) pressed[0] = ~pressed[0];
      tick(1);
    end
    pressed[0] = 1'b0;
    press_key(0, 100, 10);

    // Two keys on one column (rows 1 and 3 of column 2): never confirmed.
    pressed[6] = 1'b1;
    pressed[14] = 1'b1;
    changes = 0;
    prev = kif.col;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (kif.col !== prev) changes++;
      prev = kif.col;
    end
    tests++;
    if (changes < 20) begin
      fails++;
      $display("FAIL two_key_scan: %0d column changes, expected at least 20", changes);
    end
    pressed = 16'h0000;
    tick(20);

    // Reset in the middle of debounce of key 5.
    run = 0;
    while (kif.col !== 4'b1011 && run < 40) begin tick(1); run++; end
    check("wait_col2", {28'd0, kif.col}, 32'hB);
    pressed[5] = 1'b1;
    run = 0;
    while (kif.col !== 4'b1101 && run < 40) begin tick(1); run++; end
    check("wait_col1", {28'd0, kif.col}, 32'hD);
    tick(7);
    reset_n = 1'b0;
    #1;
    check("midrst_col", {28'd0, kif.col}, 32'hE);
    check("midrst_key_valid", {31'd0, kif.key_valid}, 32'd0);
    check("midrst_key_pressed", {31'd0, kif.key_pressed}, 32'd0);
    tick(3);
    pressed = 16'h0000;
    tick(1);
    reset_n = 1'b1;
    run = 0;
    while (kif.col === 4'b1110 && run < 3 * SD) begin tick(1); run++; end
    check("scan_resumes", {28'd0, kif.col}, 32'hD);
`ifdef KEYPAD_ENTRY_EN
    check("midrst_entry", {16'd0, kif.entry}, 32'd0);
`endif

    // Keys 1..5 in sequence.
    for (int k = 1; k <= 5; k++) press_key(k, 60, 10);
`ifdef KEYPAD_ENTRY_EN
    check("entry_2345", {16'd0, kif.entry}, 32'h2345);
`endif

    // Randomized presses.
    for (int i = 0; i < 12; i++)
      press_key($urandom_range(0, 15), $urandom_range(40, 150), $urandom_range(5, 30));

    tick(5);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_4x4_cntr.md
# keypad_4x4_cntr

Scanning reader for a 4x4 matrix keypad, the input-side counterpart of the multiplexed 4-digit FND driver.
- Drives one active-low column at a time and samples the four pulled-up row lines.
- Debounces press and release.
- Reports one hex key code per confirmed press.
- Optionally packs the last four keys into a 16-bit value that feeds the FND driver's `value` input directly.

## Interface
- `SCAN_DIV`, default 10000: clocks each column is held low; min 4.
- `DEBOUNCE_CNT`, default 100000: consecutive stable clocks required to confirm a press or a release; min 2.
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `row`, input, 4: keypad rows, active-low, externally pulled up; asynchronous to `clk`.
- `col`, output, 4: one-hot-low column drive: 1110, 1101, 1011, 0111.
- `key_value`, output, 4: code of the last confirmed key = row_idx*4 + col_idx.
- `key_valid`, output, 1: one-clock pulse when `key_value` updates.
- `key_pressed`, output, 1: level; high from confirmed press until confirmed release.
- `entry`, output, 16: last four keys, newest in [3:0]; present only with `KEYPAD_ENTRY_EN`.

## Operation
**Index definitions**
- `row` passes through a 2-flop synchronizer, giving `row_s`. All decisions use `row_s`.
- col_idx = index of the 0 bit in `col`.
- row_idx = index of the 0 bit in `row_s`.

**FSM states**
- SCAN
  - Column counter counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, `row_s` is sampled:
    - exactly one bit 0: latch `row_s` and col_idx, go DEBOUNCE, `col` frozen.
    - otherwise (1111, or two or more bits 0): rotate `col` to the next code (0111 wraps to 1110) and continue.
- DEBOUNCE
  - Counter increments each clock while `row_s` equals the latched code.
  - Any mismatch: go SCAN; `col` rotates to the next column.
  - Count reaches DEBOUNCE_CNT-1: go HOLD and, on that transition, update `key_value`, pulse `key_valid`, set `key_pressed`.
- HOLD
  - `col` stays frozen while `row_s` != 1111.
  - Any change in which rows are low, including a second key, is ignored.
  - `row_s` == 1111: go RELEASE.
- RELEASE
  - Counter increments while `row_s` == 1111.
  - Any 0 in `row_s`: go back to HOLD, counter cleared.
  - Count reaches DEBOUNCE_CNT-1: clear `key_pressed`, go SCAN, rotate `col`.

**Counter rules**
- The same counter serves the column-period and debounce roles; it clears on every state transition.
- Width is clog2(max(SCAN_DIV, DEBOUNCE_CNT)).

**Reset**
- `reset_n` low at any time immediately forces: SCAN, counter 0, `col`=1110, `key_value`=0, `key_valid`=0, `key_pressed`=0, `entry`=0, synchronizer flops=1111.
- A press in progress is discarded, with no `key_valid`.

## Timing
- Row-to-decision latency: 2 clocks (synchronizer).
- Each column settles for SCAN_DIV-1 clocks before sampling.
- Press confirmation: `key_valid` is high in the cycle after the DEBOUNCE_CNT-th consecutive matching sample in DEBOUNCE.
  - Worst case from row edge: 2 + 4*SCAN_DIV + DEBOUNCE_CNT clocks.
- `key_value`, `key_pressed` and `entry` change in the same cycle `key_valid` is high; all are registered.
- `key_valid` is never high on two consecutive clocks.
- Minimum spacing between two `key_valid` pulses: 2*DEBOUNCE_CNT + SCAN_DIV clocks.
- Release: `key_pressed` falls DEBOUNCE_CNT clocks after `row_s` first returns to 1111 and stays there.

## Configuration
- `KEYPAD_ENTRY_EN` defined:
  - `entry` port exists.
  - On each `key_valid`: `entry` <= {entry[11:0], key_value_new}.
  - Shifting is 16-bit; oldest digit drops.
- Not defined: `entry` port and its register are absent. All other behaviour is identical.

## Structure
- Package `keypad_pkg`:
  - state enum {SCAN, DEBOUNCE, HOLD, RELEASE};
  - column code constants COL0..COL3 = 1110, 1101, 1011, 0111;
  - `ROW_IDLE` = 1111.
- Sub-module `ring_counter_keypad`:
  - 4-bit one-hot-low rotator with `enable`, reset value 1110;
  - advanced by the FSM on column rotation.
- The top instantiates the synchronizer, rotator, counter and FSM.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=8.
1. Reset then idle, `row`=1111 for 64 clocks -> `col` cycles 1110, 1101, 1011, 0111 every 4 clocks; `key_valid` never high; all outputs 0.
2. Hold row 1011 whenever `col`=1101, for 200 clocks, then release -> exactly one `key_valid`, `key_value`=9 (row 2, col 1); `key_pressed` high until 8 clocks after release is seen on `row_s`.
3. Bounce: row toggles 1110/1111 every 3 clocks for 40 clocks, then stable 1110 on `col`=1110 -> no pulse during bounce; one pulse with `key_value`=0 after the stable run.
4. Two keys at once (row 0101 at one column) -> no `key_valid`, scanning continues.
5. Assert `reset_n` low mid-DEBOUNCE -> no pulse; `col`=1110 immediately; scanning resumes after release of reset.
6. With `KEYPAD_ENTRY_EN`, press keys 1, 2, 3, 4, 5 in sequence -> `entry`=16'h2345.
